// File: rtl/cdc_chan_arbiter.sv
// cdc_chan_arbiter
// Source-domain controller for one shared multi-bit CDC data channel.
// Round-robin arbitrates the requesters, holds the winning word stable on the
// crossing, launches it with a 2-phase request toggle and waits for the
// resynchronised acknowledge toggle before accepting the next word.
//
// Ports:
//   src_clk, src_rst_n  source clock, asynchronous active-low reset
//   req_valid/req_data  per-requester valid and packed words (C_DW each)
//   req_ready           one-hot accept (combinational, IDLE only)
//   xfer_data/xfer_id   word on the crossing and its owner index
//   xfer_req_tgl        request toggle to the destination domain
//   xfer_ack_tgl        acknowledge toggle from the destination (asynchronous)
//   busy                transfer outstanding
//   timeout_err/err_clr sticky handshake timeout flag and its clear
module cdc_chan_arbiter #(
    parameter int unsigned C_NUM_REQ    = 4,
    parameter int unsigned C_IDW        = 2,
    parameter int unsigned C_DW         = 32,
    parameter int unsigned C_SYNC_STAGE = 2,
    parameter int unsigned C_TIMEOUT    = 1023,
    parameter int          pTCQ         = 100
) (
    input  logic                        src_clk,
    input  logic                        src_rst_n,
    input  logic [C_NUM_REQ-1:0]        req_valid,
    input  logic [C_NUM_REQ*C_DW-1:0]   req_data,
    output logic [C_NUM_REQ-1:0]        req_ready,
    output logic [C_DW-1:0]             xfer_data,
    output logic [C_IDW-1:0]            xfer_id,
    output logic                        xfer_req_tgl,
    input  logic                        xfer_ack_tgl,
    output logic                        busy,
    output logic                        timeout_err,
    input  logic                        err_clr
);

    localparam int unsigned C_CNTW = $clog2(C_TIMEOUT + 1);
    localparam int unsigned C_PW   = C_IDW + 1;

    // Elaboration-time parameter sanity checks
    if (C_SYNC_STAGE < 2) begin : g_chk_sync
        $error("cdc_chan_arbiter: C_SYNC_STAGE must be >= 2");
    end
    if ((1 << C_IDW) < C_NUM_REQ) begin : g_chk_idw
        $error("cdc_chan_arbiter: C_IDW too narrow for C_NUM_REQ");
    end
    if (C_TIMEOUT < 1) begin : g_chk_tmo
        $error("cdc_chan_arbiter: C_TIMEOUT must be >= 1");
    end
    if (pTCQ < 0) begin : g_chk_tcq
        $error("cdc_chan_arbiter: pTCQ must be non-negative");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [C_IDW-1:0]       r_rr_ptr, w_rr_nxt;
    logic [C_DW-1:0]        r_xfer_data, w_data_nxt;
    logic [C_IDW-1:0]       r_xfer_id, w_id_nxt;
    logic                   r_req_tgl, w_tgl_nxt;
    logic [C_CNTW-1:0]      r_cnt, w_cnt_nxt;
    logic                   r_err, w_err_nxt;
    (* async_reg = "true" *) logic [C_SYNC_STAGE-1:0] r_ack_sync;

    logic                   w_ack_sync;
    logic                   w_any;
    logic                   w_err_set;
    logic [C_NUM_REQ-1:0]   w_rot;
    logic [C_PW-1:0]        w_off, w_sum, w_inc;
    logic [C_IDW-1:0]       w_win, w_win_inc;
    logic [C_DW-1:0]        w_win_data;

    assign w_any      = |req_valid;
    assign w_ack_sync = r_ack_sync[C_SYNC_STAGE-1];

    // Round-robin pick: rotate valids so rr_ptr lands at bit 0, take the
    // lowest set bit, then add the pointer back modulo C_NUM_REQ.
    always_comb begin
        w_rot = C_NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
        w_off = '0;
        for (int k = int'(C_NUM_REQ) - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = C_PW'(k);
        end
        w_sum     = C_PW'(r_rr_ptr) + w_off;
        w_win     = (w_sum >= C_PW'(C_NUM_REQ)) ? C_IDW'(w_sum - C_PW'(C_NUM_REQ))
                                                : C_IDW'(w_sum);
        w_inc     = C_PW'(w_win) + C_PW'(1);
        w_win_inc = (w_inc == C_PW'(C_NUM_REQ)) ? '0 : C_IDW'(w_inc);
        w_win_data = '0;
        req_ready  = '0;
        for (int k = 0; k < int'(C_NUM_REQ); k++) begin
            if (w_win == C_IDW'(k)) w_win_data = req_data[k*C_DW +: C_DW];
            req_ready[k] = (r_state == ST_IDLE) && w_any && (w_win == C_IDW'(k));
        end
    end

    // Next-state and datapath updates
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_data_nxt  = r_xfer_data;
        w_id_nxt    = r_xfer_id;
        w_tgl_nxt   = r_req_tgl;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_data_nxt  = w_win_data;
                    w_id_nxt    = w_win;
                    w_tgl_nxt   = ~r_req_tgl;
                    w_rr_nxt    = w_win_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Saturating count; the flag sets only on the edge it reaches the limit
                if (r_cnt != C_CNTW'(C_TIMEOUT)) begin
                    w_cnt_nxt = r_cnt + C_CNTW'(1);
                    w_err_set = (w_cnt_nxt == C_CNTW'(C_TIMEOUT));
                end
                if (w_ack_sync == r_req_tgl) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Set has priority over a coincident clear
        w_err_nxt = r_err;
        if (w_err_set)    w_err_nxt = 1'b1;
        else if (err_clr) w_err_nxt = 1'b0;
    end

    // State and datapath registers, plus acknowledge resynchroniser
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_xfer_data <= '0;
            r_xfer_id   <= '0;
            r_req_tgl   <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_ack_sync  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_xfer_data <= w_data_nxt;
            r_xfer_id   <= w_id_nxt;
            r_req_tgl   <= w_tgl_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_ack_sync  <= {r_ack_sync[C_SYNC_STAGE-2:0], xfer_ack_tgl};
        end
    end

    assign xfer_data    = r_xfer_data;
    assign xfer_id      = r_xfer_id;
    assign xfer_req_tgl = r_req_tgl;
    assign busy         = (r_state == ST_WAIT);
    assign timeout_err  = r_err;

endmodule

// File: tb/tb_cdc_chan_arbiter.sv
// Testbench for cdc_chan_arbiter: directed scenarios followed by randomized
// traffic, with a behavioural reference model, a transfer scoreboard and a
// destination-side toggle responder with programmable acknowledge delay.
module tb_cdc_chan_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int S  = 2;
    localparam int T  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   xfer_data;
    logic [1:0]      xfer_id;
    logic            xfer_req_tgl;
    logic            xfer_ack_tgl = 1'b0;
    logic            busy;
    logic            timeout_err;
    logic            err_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    int dst_delay = 0;
    bit ack_en    = 1'b1;

    // Reference model state
    bit            m_busy, m_tgl, m_err;
    int            m_rr, m_cnt, m_grant;
    logic [DW-1:0] m_data;
    logic [1:0]    m_id;
    logic          ack_q[$];
    logic [33:0]   exp_q[$];

    cdc_chan_arbiter #(
        .C_NUM_REQ(N), .C_IDW(2), .C_DW(DW), .C_SYNC_STAGE(S), .C_TIMEOUT(T), .pTCQ(100)
    ) dut (
        .src_clk(clk), .src_rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .xfer_data(xfer_data), .xfer_id(xfer_id), .xfer_req_tgl(xfer_req_tgl),
        .xfer_ack_tgl(xfer_ack_tgl), .busy(busy), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_tgl = 0; m_err = 0; m_rr = 0; m_cnt = 0; m_grant = -1;
        m_data = '0; m_id = '0;
        ack_q.delete();
        exp_q.delete();
        repeat (S) ack_q.push_back(1'b0);
    endtask

    // One source clock edge of the specified behaviour; ack seen now is the
    // value sampled S edges earlier.
    task automatic model_step();
        logic vis;
        int   w;
        bit   set;
        m_grant = -1;
        set = 0;
        vis = ack_q.pop_front();
        ack_q.push_back(xfer_ack_tgl);
        if (!m_busy) begin
            w = rr_pick(req_valid, m_rr);
            if (w >= 0) begin
                m_grant = w;
                m_data  = req_data[w*DW +: DW];
                m_id    = 2'(w);
                m_tgl   = ~m_tgl;
                m_rr    = (w + 1) % N;
                m_busy  = 1;
                m_cnt   = 0;
                exp_q.push_back({m_id, m_data});
            end
        end else begin
            if (m_cnt < T) begin
                m_cnt++;
                set = (m_cnt == T);
            end
            if (vis == m_tgl) m_busy = 0;
        end
        if (set) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Destination responder: echoes each new request toggle after dst_delay cycles
    initial begin
        int   cd;
        logic seen;
        cd = -1;
        seen = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                xfer_ack_tgl = 1'b0;
                seen = 1'b0;
                cd = -1;
            end else begin
                #1;
                if (cd < 0 && xfer_req_tgl !== seen) begin
                    seen = xfer_req_tgl;
                    cd = dst_delay;
                end else if (cd > 0) begin
                    cd--;
                end
                if (cd == 0 && ack_en) begin
                    xfer_ack_tgl = seen;
                    cd = -1;
                end
            end
        end
    end

    // Monitor: per-cycle output checks and scoreboard pop on each new transfer
    initial begin
        logic        prev_tgl;
        int          p;
        logic [N-1:0] er;
        logic [33:0] e;
        prev_tgl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tgl = 1'b0;
            end else begin
                p  = rr_pick(req_valid, m_rr);
                er = (m_busy || p < 0) ? '0 : N'(1 << p);
                chk("req_ready", req_ready, er);
                chk("busy", busy, m_busy);
                chk("timeout_err", timeout_err, m_err);
                chk("xfer_req_tgl", xfer_req_tgl, m_tgl);
                chk("xfer_data", xfer_data, m_data);
                chk("xfer_id", xfer_id, m_id);
                if (xfer_req_tgl !== prev_tgl) begin
                    prev_tgl = xfer_req_tgl;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_xfer", {xfer_id, xfer_data}, 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_xfer", {xfer_id, xfer_data}, e);
                    end
                end
            end
        end
    end

    task automatic wait_grant(output int g);
        g = -1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (m_grant >= 0) begin
                g = m_grant;
                return;
            end
        end
        chk("wait_grant_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (!m_busy) return;
        end
        chk("wait_idle_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_data"}, xfer_data, 0);
        chk({tag, "_id"}, xfer_id, 0);
        chk({tag, "_tgl"}, xfer_req_tgl, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, timeout_err, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int n;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word from requester 2, acknowledge 3 cycles after the toggle
        @(posedge clk); #1;
        dst_delay = 3;
        req_data[2*DW +: DW] = 32'hA5A5_0001;
        req_valid = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        @(posedge clk); #2;
        chk("single_ready_wait", req_ready, 4'b0000);
        chk("single_id", xfer_id, 2);
        chk("single_data", xfer_data, 32'hA5A5_0001);
        chk("single_tgl", xfer_req_tgl, 1);
        chk("single_busy", busy, 1);
        req_valid = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        for (int c = 0; c < 50 && xfer_ack_tgl !== 1'b1; c++) begin
            @(posedge clk); #2;
        end
        chk("single_ack_seen", xfer_ack_tgl, 1);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("busy_fall_latency", n, S + 1);
        chk("data_hold", xfer_data, 32'hA5A5_0001);

        // Wrap: pointer at 3, only requester 1 valid; then pointer must sit at 2
        @(posedge clk); #1;
        dst_delay = 1;
        req_data[1*DW +: DW] = $urandom;
        req_valid = 4'b0010;
        wait_grant(g);
        req_valid = '0;
        chk("wrap_id", xfer_id, 1);
        wait_idle();
        req_valid = 4'b1111;
        wait_grant(g);
        req_valid = '0;
        chk("wrap_next_id", xfer_id, 2);
        wait_idle();

        // Timeout with no acknowledge; coincident clear loses to the set
        ack_en = 1'b0;
        dst_delay = 0;
        req_data[0 +: DW] = $urandom;
        req_valid = 4'b0001;
        wait_grant(g);
        req_valid = '0;
        for (int c = 0; c < 50 && m_cnt != T - 1; c++) begin
            @(posedge clk); #1;
        end
        chk("timeout_early", timeout_err, 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("timeout_set_wins", timeout_err, 1);
        chk("timeout_busy", busy, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 0);
        ack_en = 1'b1;
        wait_idle();
        chk("timeout_recover", busy, 0);

        // Reset while a handshake is outstanding
        ack_en = 1'b0;
        req_data[1*DW +: DW] = $urandom;
        req_valid = 4'b0010;
        wait_grant(g);
        req_valid = '0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        dst_delay = 1;
        @(posedge clk); #1;
        req_data[3*DW +: DW] = $urandom;
        req_valid = 4'b1000;
        wait_grant(g);
        req_valid = '0;
        chk("post_reset_tgl", xfer_req_tgl, 1);
        chk("post_reset_id", xfer_id, 3);
        wait_idle();

        // Fairness from reset: all four valid, immediate acknowledge
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        dst_delay = 0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(g);
            chk("fair_grant", xfer_id, j % N);
            if (g >= 0) req_data[g*DW +: DW] = $urandom;
        end
        req_valid = '0;
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            err_clr = ($urandom_range(0, 19) == 0);
            dst_delay = $urandom_range(0, 9);
            for (int i = 0; i < N; i++) begin
                if (m_grant == i || !req_valid[i]) begin
                    req_data[i*DW +: DW] = $urandom;
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        err_clr = 1'b0;
        req_valid = '0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1 chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
